serial_add_seq: RTL and testbench

- Sequencer and result-capture stage for the serial adder datapath.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and drives the adder's parallel-load, shift and carry-clear controls for exactly WIDTH shift cycles.
- Captures the serial sum and final carry, then presents them downstream over a second valid/ready handshake.
- Sits directly upstream of the adder, which it controls, and consumes the adder's sum/cout outputs.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_add_seq.sv | 124 ++++++++++++
 tb/tb_serial_add_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder sequencer.
// State encoding is fixed at 3 bits so that illegal codes can be detected and recovered.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/serial_add_seq.sv
// Sequencer and result-capture stage for the serial adder datapath.
// Loads an operand pair, shifts the adder WIDTH times, captures sum/carry and hands the result downstream.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_pipo,
  output logic             add_shift,
  output logic             add_clear_n,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign out_sum  = sum_q;
  assign out_cout = cout_q;

  // State, counter, operand and result registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      add_a_q <= {WIDTH{1'b0}};
      add_b_q <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic; adder controls depend on state only, never on handshake inputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready    = 1'b0;
    add_pipo    = 1'b0;
    add_shift   = 1'b0;
    add_clear_n = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          add_a_d = in_a;
          add_b_d = in_b;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        add_pipo = 1'b1;
        cnt_d    = {CNT_W{1'b0}};
        state_d  = SHIFT;
      end
      SHIFT: begin
        add_shift   = 1'b1;
        add_clear_n = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        // Carry-out of the top bit is only valid before the final shift edge.
        if (cnt_q == LAST_CNT) begin
          cout_d  = add_cout;
          state_d = CAPT;
        end else begin
          state_d = SHIFT;
        end
      end
      CAPT: begin
        sum_d   = add_sum;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq paired with a behavioural 4-bit serial adder.
// Expected sums and carries below are hand-computed.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [3:0] add_a, add_b;
  logic       add_pipo, add_shift, add_clear_n;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       out_valid, out_ready;
  logic [3:0] out_sum;
  logic       out_cout;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  int out_hs  = 0;
  int ready_bad = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_pipo(add_pipo), .add_shift(add_shift),
    .add_clear_n(add_clear_n), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .busy(busy)
  );

  // Behavioural serial adder: A/B shift registers plus a gated, async-cleared carry flop.
  logic [3:0] ra = 4'd0;
  logic [3:0] rb = 4'd0;
  logic       rc = 1'b0;
  assign add_sum  = ra;
  assign add_cout = (ra[0] & rb[0]) | (ra[0] & rc) | (rb[0] & rc);

  always @(posedge clk) begin
    if (add_pipo) begin
      ra <= add_a;
      rb <= add_b;
    end else if (add_shift) begin
      ra <= {ra[0] ^ rb[0] ^ rc, ra[3:1]};
      rb <= {1'b0, rb[3:1]};
    end
  end

  always @(posedge clk or negedge add_clear_n) begin
    if (!add_clear_n) rc <= 1'b0;
    else if (add_shift) rc <= add_cout;
  end

  // Handshake bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!clear && in_valid && in_ready) begin
      acc_cyc <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (!clear && out_valid && out_ready) out_hs <= out_hs + 1;
  end

  always @(negedge clk) begin
    if (!clear && (in_ready == busy)) ready_bad <= ready_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input int prev);
    int n;
    n = 0;
    while (acc_cnt == prev && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", 32'(acc_cnt != prev), 32'd1);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    int prev;
    prev = acc_cnt;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    wait_accept(prev);
  endtask

  // Called at the negedge right after the accept edge; runs until out_valid.
  task automatic wait_done(input string tag, input logic [3:0] es, input logic ec);
    int n, npipo, nshift, nbad;
    n = 0; npipo = 0; nshift = 0; nbad = 0;
    while (!out_valid && n < 40) begin
      if (add_pipo) npipo++;
      if (add_shift) begin
        nshift++;
        if (!add_clear_n) nbad++;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc - 1), 32'd6);
    chk({tag, "_pipo_cycles"}, 32'(npipo), 32'd1);
    chk({tag, "_shift_cycles"}, 32'(nshift), 32'd4);
    chk({tag, "_clear_n_in_shift"}, 32'(nbad), 32'd0);
    chk({tag, "_sum"}, 32'(out_sum), 32'(es));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
  endtask

  initial begin
    int a1, p, h, bad;
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_clear_n", 32'(add_clear_n), 32'd0);
    chk("rst_pipo_shift", 32'({add_pipo, add_shift}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_regs", 32'({add_a, add_b, out_sum, out_cout}), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // 4 + 1
    out_ready = 1'b1;
    @(negedge clk);
    issue(4'b0100, 4'b0001);
    in_valid = 1'b0;
    chk("t1_ready_low", 32'(in_ready), 32'd0);
    wait_done("t1", 4'b0101, 1'b0);
    @(negedge clk);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd1);

    // Carry generation, then no stale carry into the next operation
    issue(4'b1111, 4'b0001);
    in_valid = 1'b0;
    wait_done("t2a", 4'b0000, 1'b1);
    @(negedge clk);
    issue(4'b1010, 4'b0110);
    in_valid = 1'b0;
    wait_done("t2b", 4'b0000, 1'b1);
    @(negedge clk);

    // Back-to-back with in_valid held
    issue(4'b0011, 4'b0101);
    a1 = acc_cyc;
    p = acc_cnt;
    in_a = 4'b0111;
    in_b = 4'b0111;
    wait_done("t3a", 4'b1000, 1'b0);
    wait_accept(p);
    in_valid = 1'b0;
    chk("t3_issue_interval", 32'(acc_cyc - a1), 32'd8);
    wait_done("t3b", 4'b1110, 1'b0);
    @(negedge clk);

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(4'b0010, 4'b0011);
    in_valid = 1'b0;
    wait_done("t4", 4'b0101, 1'b0);
    p = acc_cnt;
    h = out_hs;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a = 4'b1111;
      in_b = 4'b1111;
      if (!out_valid || out_sum != 4'b0101) bad++;
    end
    in_valid = 1'b0;
    chk("t4_hold", 32'(bad), 32'd0);
    chk("t4_no_accept", 32'(acc_cnt), 32'(p));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_release_drop", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_one_result", 32'(out_hs - h), 32'd1);

    // Clear during the second shift cycle
    out_ready = 1'b1;
    issue(4'b1111, 4'b1111);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("t5_clear_n", 32'(add_clear_n), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_idle", 32'({busy, in_ready, add_shift}), 32'b010);
    chk("t5_carry_cleared", 32'(rc), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    issue(4'b0110, 4'b0011);
    in_valid = 1'b0;
    wait_done("t5", 4'b1001, 1'b0);
    @(negedge clk);

    // Operands presented while busy are ignored
    out_ready = 1'b0;
    issue(4'b0101, 4'b0100);
    p = acc_cnt;
    in_a = 4'b1111;
    in_b = 4'b1111;
    wait_done("t6", 4'b1001, 1'b0);
    in_valid = 1'b0;
    chk("t6_add_a", 32'(add_a), 32'd5);
    chk("t6_add_b", 32'(add_b), 32'd4);
    chk("t6_no_accept", 32'(acc_cnt), 32'(p));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    chk("ready_vs_busy", 32'(ready_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
